// File: rtl/hcsr04_pkg.sv
// Shared types and default timing constants for the HC-SR04 range controller.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE
    } state_t;

    localparam int TRIG_CYCLES_DEF  = 500;
    localparam int CLK_PER_MM_DEF   = 294;
    localparam int MAX_MM_DEF       = 4000;
    localparam int WAIT_TIMEOUT_DEF = 1_900_000;

    localparam logic [11:0] DIST_TIMEOUT = 12'hFFF;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hcsr04_ranger_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with one-cycle rise and fall pulses
// derived from the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 controller: fires the trigger pulse, times the echo, reports distance in mm.
//
// state     | meaning
// IDLE      | waiting for start, last result held on distance/val
// TRIG      | trigger pin high for TRIG_CYCLES cycles
// WAIT_ECHO | waiting for echo to go high, bounded by WAIT_TIMEOUT
// MEASURE   | echo high, prescaler ticks the mm counter
// DONE      | one cycle, result registered and val raised
module hcsr04_ranger
    import hcsr04_pkg::*;
#(
    parameter int TRIG_CYCLES  = TRIG_CYCLES_DEF,
    parameter int CLK_PER_MM   = CLK_PER_MM_DEF,
    parameter int MAX_MM       = MAX_MM_DEF,
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic [11:0] distance,
    output logic        val
);

    localparam int TW = cnt_width(TRIG_CYCLES);
    localparam int EW = cnt_width(WAIT_TIMEOUT);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] cnt_t;
    logic [EW-1:0] cnt_e;
    logic [EW-1:0] cnt_w;
    logic [11:0]   mm;
    logic          tmo;

    logic echo_s;
    logic echo_rise;
    logic echo_fall;

    logic trig_end;
    logic wait_end;
    logic meas_end;
    logic tick_end;
    logic echo_seen;

    sync_edge u_sync_echo (
        .clk  (clk),
        .rst  (rst),
        .d    (echo),
        .q    (echo_s),
        .rise (echo_rise),
        .fall (echo_fall)
    );

    assign trig_end = (cnt_t == TW'(TRIG_CYCLES - 1));
    assign wait_end = (cnt_e == EW'(WAIT_TIMEOUT - 1));
    assign meas_end = (cnt_w == EW'(WAIT_TIMEOUT - 1));
    assign tick_end = (cnt_e == EW'(CLK_PER_MM - 1));
    // The level term lets an echo that is already high on entry start the measurement.
    assign echo_seen = echo_rise | echo_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = TRIG;
            TRIG:      if (trig_end) state_nx = WAIT_ECHO;
            WAIT_ECHO: begin
                if (echo_seen) begin
                    state_nx = MEASURE;
                end else if (wait_end) begin
                    state_nx = DONE;
                end
            end
            MEASURE:   if (echo_fall || meas_end) state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig     <= 1'b0;
            distance <= 12'd0;
            val      <= 1'b0;
            cnt_t    <= '0;
            cnt_e    <= '0;
            cnt_w    <= '0;
            mm       <= 12'd0;
            tmo      <= 1'b0;
        end else begin
            trig <= (state_nx == TRIG);
            case (state)
                IDLE: begin
                    if (start) begin
                        val   <= 1'b0;
                        cnt_t <= '0;
                        cnt_e <= '0;
                        cnt_w <= '0;
                        mm    <= 12'd0;
                        tmo   <= 1'b0;
                    end
                end
                TRIG: begin
                    if (!trig_end) cnt_t <= cnt_t + 1'b1;
                end
                WAIT_ECHO: begin
                    if (echo_seen) begin
                        cnt_e <= '0;
                        cnt_w <= '0;
                    end else if (wait_end) begin
                        tmo <= 1'b1;
                    end else begin
                        cnt_e <= cnt_e + 1'b1;
                    end
                end
                MEASURE: begin
                    if (!meas_end) cnt_w <= cnt_w + 1'b1;
                    if (meas_end && !echo_fall) tmo <= 1'b1;
                    // The exit cycle still counts, so W echo cycles yield floor(W/CLK_PER_MM).
                    if (tick_end) begin
                        cnt_e <= '0;
                        if (mm != 12'(MAX_MM)) mm <= mm + 12'd1;
                    end else begin
                        cnt_e <= cnt_e + 1'b1;
                    end
                end
                DONE: begin
                    distance <= tmo ? DIST_TIMEOUT : mm;
                    val      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger with scaled timing: 20-cycle trigger, 10 cycles/mm,
// 100 mm ceiling, 2000-cycle timeout.
module tb_hcsr04_ranger;
    import hcsr04_pkg::*;

    localparam int TRIG_CYC = 20;
    localparam int CPM      = 10;
    localparam int MAXMM    = 100;
    localparam int WTO      = 2000;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic        echo  = 1'b0;
    logic        trig;
    logic [11:0] distance;
    logic        val;

    int n_run  = 0;
    int n_fail = 0;

    hcsr04_ranger #(
        .TRIG_CYCLES  (TRIG_CYC),
        .CLK_PER_MM   (CPM),
        .MAX_MM       (MAXMM),
        .WAIT_TIMEOUT (WTO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .echo     (echo),
        .trig     (trig),
        .distance (distance),
        .val      (val)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges with trig high until it drops; returns at the first low sample.
    task automatic wait_trig(output int hi);
        int i;
        hi = 0;
        i  = 0;
        while (!trig && i < 100) begin
            @(negedge clk);
            i++;
        end
        while (trig && hi < 1000) begin
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic wait_val(input string tag, input int budget);
        int i;
        i = 0;
        while (!val && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_val_set"}, 32'(val), 32'd1);
    endtask

    task automatic measure(input string tag, input int dly, input int width,
                           input int poke, input logic [11:0] exp);
        int hi;
        pulse_start();
        chk({tag, "_val_clr"}, 32'(val), 32'd0);
        wait_trig(hi);
        chk({tag, "_trig_len"}, hi, TRIG_CYC);
        repeat (dly) @(negedge clk);
        if (width > 0) begin
            echo = 1'b1;
            if (poke != 0) begin
                repeat (width / 2) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (width - width / 2 - 1) @(negedge clk);
            end else begin
                repeat (width) @(negedge clk);
            end
            echo = 1'b0;
        end
        wait_val(tag, WTO + 100);
        chk({tag, "_dist"}, 32'(distance), 32'(exp));
    endtask

    initial begin
        int hi;

        repeat (3) @(negedge clk);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_dist", 32'(distance), 32'd0);
        chk("rst_val", 32'(val), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_cnt_t", 32'(dut.cnt_t), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        measure("m45", 10, 455, 0, 12'd45);
        repeat (50) @(negedge clk);
        chk("m45_val_hold", 32'(val), 32'd1);
        chk("m45_dist_hold", 32'(distance), 32'd45);
        chk("m45_idle", 32'(dut.state), 32'(IDLE));

        // Second start during TRIG must neither stretch nor repeat the trigger.
        pulse_start();
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            if (trig) hi++;
            if (i == 5) start = 1'b1;
            if (i == 6) start = 1'b0;
            @(negedge clk);
        end
        chk("trig_poke_len", hi, TRIG_CYC);
        echo = 1'b1;
        repeat (255) @(negedge clk);
        echo = 1'b0;
        wait_val("trig_poke", WTO + 100);
        chk("trig_poke_dist", 32'(distance), 32'd25);

        measure("sat", 5, 1200, 0, 12'd100);
        measure("short", 3, 5, 0, 12'd0);
        measure("edge100", 5, 1005, 0, 12'd100);
        measure("near_tmo", 0, 1990, 0, 12'd100);
        measure("noecho", 0, 0, 0, DIST_TIMEOUT);

        echo = 1'b1;
        measure("stuck", 0, 0, 0, DIST_TIMEOUT);
        echo = 1'b0;
        repeat (5) @(negedge clk);

        measure("poke", 10, 655, 1, 12'd65);
        repeat (5) @(negedge clk);
        chk("poke_idle", 32'(dut.state), 32'(IDLE));
        chk("poke_trig", 32'(trig), 32'd0);
        measure("again", 10, 305, 0, 12'd30);

        pulse_start();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_trig", 32'(trig), 32'd0);
        chk("mid_rst_dist", 32'(distance), 32'd0);
        chk("mid_rst_val", 32'(val), 32'd0);
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_trig", 32'(trig), 32'd0);

        measure("post_rst", 10, 455, 0, 12'd45);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
